// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the pipeline hazard controller:
//     state_t  - sequencing states of the controller FSM
//     FWD_*    - ALU operand forward-select encodings driven to the E stage
package hazard_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

endpackage : hazard_pkg

// File: rtl/forward_select.sv
// forward_select
//   Combinational forward-select for one E-stage ALU operand. The M stage
//   holds the younger result, so it takes priority over W. Register x0 is
//   hard-wired to zero and is never forwarded.
//   Ports:
//     rs           in  5  source register of the operand in E
//     rd_m         in  5  destination register in M
//     reg_write_m  in  1  M instruction writes the register file
//     rd_w         in  5  destination register in W
//     reg_write_w  in  1  W instruction writes the register file
//     fwd          out 2  FWD_RF / FWD_WB / FWD_MEM
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule : forward_select

// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and sequencing controller for the 5-stage RISC-V pipeline.
//   Produces the F/D stall, D/E flush and E-stage forward selects, sequences
//   BOOT -> RUN -> DRAIN -> HALTED, and counts stall and flush events.
//   Parameters:
//     DRAIN_CYCLES  bubble cycles needed to empty D, E, M and W (>= 1)
//     CNT_W         width of each saturating event counter
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     Rs1D, Rs2D                   sources of the instruction in D
//     Rs1E, Rs2E, RdE              sources / destination in E
//     ResultSrcE                   instruction in E is a load
//     PCSrcE                       taken branch resolved in E
//     RdM, RegWriteM               destination / write enable in M
//     RdW, RegWriteW               destination / write enable in W
//     halt_req                     level request to halt the pipeline
//     StallF, StallD               hold PC / hold D register (combinational)
//     FlushD, FlushE               clear D / E register at next edge (combinational)
//     ForwardAE, ForwardBE         ALU operand selects (combinational)
//     halted                       pipeline empty and frozen (registered)
//     stall_count, flush_count     saturating event counters (registered)
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             halt_req,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Drain counter counts DRAIN_CYCLES-1 down to 0; keep at least one bit.
  localparam int         DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t          state;
  logic [DW-1:0]   drain_cnt;
  logic            lw_stall;
  logic            stall_evt;   // load-use stall actually applied this cycle
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;

  // ---------------------------------------------------------------------------
  // Forwarding: identical logic for both operands, suppressed only in reset.
  // ---------------------------------------------------------------------------
  forward_select u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_select u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;

  // A load in E whose destination is read by the instruction in D cannot be
  // forwarded in time; D must wait one cycle behind a bubble.
  assign lw_stall = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // ---------------------------------------------------------------------------
  // Stall / flush controls: combinational from state and inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    stall_evt = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      unique case (state)
        BOOT: begin
          StallF = 1'b1;
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
        RUN: begin
          // A taken branch squashes the dependent instruction anyway, so the
          // flush wins over a simultaneous load-use stall.
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            FlushE    = 1'b1;
            stall_evt = 1'b1;
          end
        end
        DRAIN: begin
          // Freeze fetch and feed bubbles into D until the pipe is empty.
          StallF = 1'b1;
          FlushD = 1'b1;
          if (PCSrcE) begin
            // Let the PC take the branch target so resume starts at the
            // correct address; the wrong-path instructions are squashed.
            StallF = 1'b0;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            // The stalled consumer in D is still live and must not be lost.
            StallD    = 1'b1;
            FlushE    = 1'b1;
            FlushD    = 1'b0;
            stall_evt = 1'b1;
          end
        end
        HALTED: begin
          StallF = 1'b1;
          StallD = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM, drain counter, halted flag and event counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all state here is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= BOOT;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          // A held load-use stall keeps an instruction in D, so the drain
          // budget is paused; halt_req is no longer consulted here.
          if (!stall_evt) begin
            if (drain_cnt == '0) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - DW'(1);
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
      endcase

      if (stall_evt && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (PCSrcE && (state != BOOT) && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule : hazard_controller
